ps_conv_ctrl: RTL and testbench

- Sequencer and arbiter for the shared 32-to-8 parallel-serial converter in the 8-bit AES datapath.
- Two 32-bit word requesters share the converter: src A is the data/state column path, src B is the key-schedule word path.
- The block grants one requester at a time, drives the converter's parallel-load strobe and word input, and tags each serial byte with valid, index, source and last flags.
- Optional per-source lock keeps a grant across consecutive words, so a full 128-bit block serializes uninterrupted.

---
 rtl/ps_conv_ctrl.sv | 137 +++++++++++++
 tb/tb_ps_conv_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_conv_ctrl.sv
// ps_conv_ctrl: sequencer and round-robin arbiter for the shared 32-to-8
// parallel-serial converter in the 8-bit AES datapath.
//
// Source A (data/state columns) and source B (key-schedule words) each offer
// a 32-bit word. One word is granted at a time. The block pulses the
// converter's parallel load and presents the word. The converter then emits
// four bytes, MSB first, and this block tags each one with valid, index,
// source and last.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   a_word/a_valid/a_lock  source A request (word held until a_ready)
//   a_ready                source A word accepted this cycle
//   b_word/b_valid/b_lock  source B request
//   b_ready                source B word accepted this cycle
//   conv_pld               converter parallel load (1) / shift (0)
//   conv_pdin              converter parallel word input
//   byte_valid             converter dout carries a valid byte
//   byte_idx               byte index in word, 0 = bits [31:24]
//   byte_src               source of current byte (0 = A, 1 = B)
//   byte_last              high on byte index 3
module ps_conv_ctrl #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned BYTE_W    = 8,
  parameter bit          INIT_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] a_word,
  input  logic              a_valid,
  input  logic              a_lock,
  output logic              a_ready,
  input  logic [WORD_W-1:0] b_word,
  input  logic              b_valid,
  input  logic              b_lock,
  output logic              b_ready,
  output logic              conv_pld,
  output logic [WORD_W-1:0] conv_pdin,
  output logic              byte_valid,
  output logic [1:0]        byte_idx,
  output logic              byte_src,
  output logic              byte_last
);

  // The converter is exactly four stages deep.
  if (WORD_W != 4 * BYTE_W) begin : g_bad_width
    $error("ps_conv_ctrl: WORD_W must equal 4 * BYTE_W");
  end

  // State encoding doubles as the byte index of the byte being emitted.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StS1   = 2'd1;
  localparam logic [1:0] StS2   = 2'd2;
  localparam logic [1:0] StS3   = 2'd3;

  logic [1:0] state_q, state_d;
  logic       last_src_q, last_src_d;
  logic       lock_q, lock_d;

  logic       lock_hold;
  logic       grant;
  logic       grant_src;

  // Arbitration. The locked source is always the most recently granted one.
  always_comb begin
    lock_hold = lock_q && (last_src_q ? b_valid : a_valid);
    if (lock_hold) begin
      grant_src = last_src_q;
    end else if (a_valid && b_valid) begin
      grant_src = ~last_src_q;
    end else begin
      grant_src = b_valid;
    end
    grant = (state_q == StIdle) && (a_valid || b_valid);
  end

  always_comb begin
    state_d    = state_q;
    last_src_d = last_src_q;
    lock_d     = lock_q;
    case (state_q)
      StIdle: begin
        if (grant) begin
          state_d    = StS1;
          last_src_d = grant_src;
          lock_d     = grant_src ? b_lock : a_lock;
        end else begin
          // An unused lock expires at the first idle decision.
          lock_d = 1'b0;
        end
      end
      StS1:    state_d = StS2;
      StS2:    state_d = StS3;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_src_q <= ~INIT_PRIO;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_src_q <= last_src_d;
      lock_q     <= lock_d;
    end
  end

  // Outputs are forced low while rst is high, including mid-word.
  always_comb begin
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    conv_pld   = 1'b0;
    conv_pdin  = '0;
    byte_valid = 1'b0;
    byte_idx   = 2'd0;
    byte_src   = 1'b0;
    byte_last  = 1'b0;
    if (!rst) begin
      if (grant) begin
        conv_pld   = 1'b1;
        conv_pdin  = grant_src ? b_word : a_word;
        a_ready    = ~grant_src;
        b_ready    = grant_src;
        byte_valid = 1'b1;
        byte_src   = grant_src;
      end else if (state_q != StIdle) begin
        byte_valid = 1'b1;
        byte_idx   = state_q;
        byte_src   = last_src_q;
        byte_last  = (state_q == StS3);
      end
    end
  end

endmodule

// File: tb/tb_ps_conv_ctrl.sv
module tb_ps_conv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_word = '0;
  logic        a_valid = 1'b0;
  logic        a_lock = 1'b0;
  logic        a_ready;
  logic [31:0] b_word = '0;
  logic        b_valid = 1'b0;
  logic        b_lock = 1'b0;
  logic        b_ready;
  logic        conv_pld;
  logic [31:0] conv_pdin;
  logic        byte_valid;
  logic [1:0]  byte_idx;
  logic        byte_src;
  logic        byte_last;

  ps_conv_ctrl #(
    .WORD_W   (32),
    .BYTE_W   (8),
    .INIT_PRIO(1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_word    (a_word),
    .a_valid   (a_valid),
    .a_lock    (a_lock),
    .a_ready   (a_ready),
    .b_word    (b_word),
    .b_valid   (b_valid),
    .b_lock    (b_lock),
    .b_ready   (b_ready),
    .conv_pld  (conv_pld),
    .conv_pdin (conv_pdin),
    .byte_valid(byte_valid),
    .byte_idx  (byte_idx),
    .byte_src  (byte_src),
    .byte_last (byte_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural converter fed by the DUT's load/word outputs.
  logic [31:0] conv_sreg = '0;
  always @(posedge clk) conv_sreg <= conv_pld ? (conv_pdin << 8) : (conv_sreg << 8);
  wire [7:0] conv_dout = conv_pld ? conv_pdin[31:24] : conv_sreg[31:24];

  // Scoreboard entry: {last, src, idx[1:0], byte[7:0]}.
  logic [11:0] exp_q[$];
  logic        grant_src_log[$];
  int          grant_cyc_log[$];

  // Reference model state.
  int   m_phase = 0;  // 0 = idle, 1..3 = bytes 1..3 pending
  logic m_last  = 1'b1;
  logic m_lock  = 1'b0;
  int   cyc     = 0;
  logic a_acc   = 1'b0;
  logic b_acc   = 1'b0;

  always @(negedge clk) begin
    logic        want_grant;
    logic        win;
    logic [31:0] w;
    logic [11:0] e;
    cyc++;
    if (rst) begin
      check("rst_a_ready", {31'd0, a_ready}, 0);
      check("rst_b_ready", {31'd0, b_ready}, 0);
      check("rst_pld", {31'd0, conv_pld}, 0);
      check("rst_pdin", conv_pdin, 0);
      check("rst_tags", {28'd0, byte_valid, byte_idx, byte_src} | {31'd0, byte_last}, 0);
      exp_q.delete();
      m_phase = 0;
      m_last  = 1'b1;  // ~INIT_PRIO
      m_lock  = 1'b0;
      a_acc   = 1'b0;
      b_acc   = 1'b0;
    end else begin
      want_grant = (m_phase == 0) && (a_valid || b_valid);
      win = 1'b0;
      if (want_grant) begin
        if (m_lock && ((m_last == 1'b0 && a_valid) || (m_last == 1'b1 && b_valid))) win = m_last;
        else if (a_valid && b_valid) win = !m_last;
        else win = !a_valid;
      end
      check("a_ready", {31'd0, a_ready}, {31'd0, want_grant && !win});
      check("b_ready", {31'd0, b_ready}, {31'd0, want_grant && win});
      check("pld", {31'd0, conv_pld}, {31'd0, want_grant});
      check("byte_valid", {31'd0, byte_valid}, {31'd0, want_grant || (m_phase != 0)});
      if (want_grant) begin
        w = win ? b_word : a_word;
        check("pdin", conv_pdin, w);
        for (int k = 0; k < 4; k++) begin
          e = {(k == 3), win, k[1:0], w[31-8*k -: 8]};
          exp_q.push_back(e);
        end
        grant_src_log.push_back(win);
        grant_cyc_log.push_back(cyc);
      end else begin
        check("pdin_idle", conv_pdin, 0);
      end
      if (byte_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("dout", {24'd0, conv_dout}, {24'd0, e[7:0]});
          check("idx", {30'd0, byte_idx}, {30'd0, e[9:8]});
          check("src", {31'd0, byte_src}, {31'd0, e[10]});
          check("last", {31'd0, byte_last}, {31'd0, e[11]});
        end
      end
      if (m_phase == 0) begin
        if (want_grant) begin
          m_phase = 1;
          m_last  = win;
          m_lock  = win ? b_lock : a_lock;
        end else begin
          m_lock = 1'b0;
        end
      end else begin
        m_phase = (m_phase == 3) ? 0 : m_phase + 1;
      end
      a_acc = a_ready;
      b_acc = b_ready;
    end
  end

  // Requester models: present the head of each queue until accepted.
  logic [31:0] a_src_q[$];
  logic [31:0] b_src_q[$];
  bit          lock_mode = 1'b0;
  int          a_cnt = 0;

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (a_acc && a_src_q.size() > 0) begin
        void'(a_src_q.pop_front());
        a_cnt++;
      end
      if (b_acc && b_src_q.size() > 0) void'(b_src_q.pop_front());
      a_valid = (a_src_q.size() > 0);
      a_word  = a_valid ? a_src_q[0] : 32'd0;
      b_valid = (b_src_q.size() > 0);
      b_word  = b_valid ? b_src_q[0] : 32'd0;
      a_lock  = lock_mode && (a_cnt < 3);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_src_q.delete();
    b_src_q.delete();
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_lock  = 1'b0;
    lock_lode_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    grant_src_log.delete();
    grant_cyc_log.delete();
  endtask

  task automatic lock_lode_clear();
    lock_mode = 1'b0;
    a_cnt     = 0;
  endtask

  initial begin
    // Reset held for a few cycles; every negedge under rst checks all-zero outputs.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word.
    do_reset();
    a_src_q.push_back(32'h11223344);
    run(8);
    check("single_grants", grant_src_log.size(), 1);
    if (grant_src_log.size() == 1) check("single_src", {31'd0, grant_src_log[0]}, 0);

    // Contention: strict alternation, one load every 4 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_src_q.push_back(32'hA0A1A2A3 + i);
      b_src_q.push_back(32'hB0B1B2B3 + i);
    end
    run(36);
    check("rr_grants", grant_src_log.size(), 8);
    if (grant_src_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("rr_src%0d", i), {31'd0, grant_src_log[i]}, i % 2);
        if (i > 0) check($sformatf("rr_gap%0d", i), grant_cyc_log[i] - grant_cyc_log[i-1], 4);
      end
    end

    // Lock: A keeps the grant for four words, then B wins.
    do_reset();
    lock_mode = 1'b1;
    for (int i = 0; i < 6; i++) a_src_q.push_back(32'hC0000000 + i);
    for (int i = 0; i < 3; i++) b_src_q.push_back(32'hD0000000 + i);
    run(40);
    check("lock_grants", grant_src_log.size(), 9);
    if (grant_src_log.size() >= 6) begin
      for (int i = 0; i < 4; i++) check($sformatf("lock_a%0d", i), {31'd0, grant_src_log[i]}, 0);
      check("lock_then_b", {31'd0, grant_src_log[4]}, 1);
      check("lock_then_a", {31'd0, grant_src_log[5]}, 0);
    end
    lock_mode = 1'b0;

    // Valid withdrawal: B pulses for one cycle during S2 of an A word.
    do_reset();
    a_src_q.push_back(32'h01020304);
    a_src_q.push_back(32'h05060708);
    run(3);
    b_valid = 1'b1;
    b_word  = 32'hBBBBBBBB;
    run(10);
    check("wd_grants", grant_src_log.size(), 2);
    foreach (grant_src_log[i]) check($sformatf("wd_src%0d", i), {31'd0, grant_src_log[i]}, 0);

    // Reset during S2: remaining bytes abandoned, next A word loads at once.
    do_reset();
    a_src_q.push_back(32'hDEADBEEF);
    a_src_q.push_back(32'h12345678);
    run(3);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    grant_src_log.delete();
    grant_cyc_log.delete();
    run(7);
    check("mid_rst_grants", grant_src_log.size(), 1);
    if (grant_src_log.size() == 1) check("mid_rst_src", {31'd0, grant_src_log[0]}, 0);

    // Back-to-back from one source.
    do_reset();
    for (int i = 0; i < 3; i++) a_src_q.push_back(32'h10203040 * (i + 1));
    run(16);
    check("b2b_grants", grant_src_log.size(), 3);
    if (grant_src_log.size() == 3) begin
      check("b2b_gap1", grant_cyc_log[1] - grant_cyc_log[0], 4);
      check("b2b_gap2", grant_cyc_log[2] - grant_cyc_log[1], 4);
    end

    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
